// File: rtl/prm_edge_chk_sched.sv
// -----------------------------------------------------------------------------
// prm_edge_chk_sched
//   Sequencer for the PRM obstacle-logic checker bank. Walks the roadmap edge
//   indices from first_edge_i to last_edge_i (inclusive). For each edge it
//   drives the edge code and an obstacle-group select to the shared bank. It
//   then masks the returned hits with the enabled obstacles of that group and
//   streams one blocked/free result per edge through a valid/ready handshake.
//   Groups without enabled obstacles are skipped. The first hit ends the
//   group scan for that edge.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous reset, active-high
//   start_i        begin a scan (accepted only when idle)
//   abort_i        stop the current scan; no done pulse
//   first_edge_i   first edge index (inclusive)
//   last_edge_i    last edge index (inclusive)
//   obs_en_i       obstacle enables; bit g*NUM_OBS+k = checker k of group g
//   chk_edge_o     edge code to the checker bank (registered)
//   chk_grp_o      group select to the bank mux (registered)
//   chk_mask_i     hit outputs of the selected group
//   res_valid_o    result available
//   res_ready_i    consumer accepts the result
//   res_edge_o     edge index of the result
//   res_block_o    1 = edge collides with at least one enabled obstacle
//   busy_o         high in every state except idle
//   blk_cnt_o      number of accepted blocked results (optional)
//   done_o         one-cycle pulse after the last result is accepted
//
// Configuration
//   PRM_EDGE_SCHED_CNT_EN  define to add the blk_cnt_o blocked-result counter
// -----------------------------------------------------------------------------
module prm_edge_chk_sched #(
   parameter int  EDGE_W  = 15,
   parameter int  NUM_OBS = 16,
   parameter int  NUM_GRP = 4,
   localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       abort_i,
   input  logic [EDGE_W-1:0]          first_edge_i,
   input  logic [EDGE_W-1:0]          last_edge_i,
   input  logic [NUM_OBS*NUM_GRP-1:0] obs_en_i,
   output logic [EDGE_W-1:0]          chk_edge_o,
   output logic [GRP_W-1:0]           chk_grp_o,
   input  logic [NUM_OBS-1:0]         chk_mask_i,
   output logic                       res_valid_o,
   input  logic                       res_ready_i,
   output logic [EDGE_W-1:0]          res_edge_o,
   output logic                       res_block_o,
   output logic                       busy_o,
`ifdef PRM_EDGE_SCHED_CNT_EN
   output logic [EDGE_W:0]            blk_cnt_o,
`endif
   output logic                       done_o
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SAMPLE, S_EMIT, S_DONE} state_e;

   state_e                     state_q, state_d;
   // One extra bit so that last_edge = 2^EDGE_W-1 never wraps the index.
   logic [EDGE_W:0]            idx_q, idx_d;
   logic [EDGE_W-1:0]          last_q, last_d;
   logic [NUM_OBS*NUM_GRP-1:0] obs_en_q, obs_en_d;
   logic [GRP_W-1:0]           grp_q, grp_d;
   logic [EDGE_W-1:0]          chk_edge_q, chk_edge_d;
   logic                       block_q, block_d;
`ifdef PRM_EDGE_SCHED_CNT_EN
   logic [EDGE_W:0]            cnt_q, cnt_d;
`endif

   logic [NUM_GRP-1:0] grp_act_in;   // groups with any enable, from the live input
   logic [NUM_GRP-1:0] grp_act_lat;  // groups with any enable, from the latched copy
   logic [NUM_OBS-1:0] sel_en;       // enable slice of the currently selected group
   logic [GRP_W:0]     first_in, first_lat, next_lat, next_from;
   logic               hit;

   // Returns {found, index} of the lowest active group at or above 'from'.
   function automatic logic [GRP_W:0] find_grp(input logic [NUM_GRP-1:0] en,
                                               input logic [GRP_W:0]     from);
      logic [GRP_W:0] res;
      res = '0;
      for (int g = NUM_GRP - 1; g >= 0; g--) begin
         if (en[g] && (g >= int'(from))) res = {1'b1, GRP_W'(g)};
      end
      return res;
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      grp_act_in  = '0;
      grp_act_lat = '0;
      sel_en      = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         grp_act_in[g]  = |obs_en_i[g*NUM_OBS +: NUM_OBS];
         grp_act_lat[g] = |obs_en_q[g*NUM_OBS +: NUM_OBS];
         if (grp_q == GRP_W'(g)) sel_en = obs_en_q[g*NUM_OBS +: NUM_OBS];
      end
   end

   assign next_from = {1'b0, grp_q} + {{GRP_W{1'b0}}, 1'b1};
   assign first_in  = find_grp(grp_act_in, '0);
   assign first_lat = find_grp(grp_act_lat, '0);
   assign next_lat  = find_grp(grp_act_lat, next_from);
   assign hit       = |(chk_mask_i & sel_en);

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         last_q     <= '0;
         obs_en_q   <= '0;
         grp_q      <= '0;
         chk_edge_q <= '0;
         block_q    <= 1'b0;
`ifdef PRM_EDGE_SCHED_CNT_EN
         cnt_q      <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         obs_en_q   <= obs_en_d;
         grp_q      <= grp_d;
         chk_edge_q <= chk_edge_d;
         block_q    <= block_d;
`ifdef PRM_EDGE_SCHED_CNT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   // Next state and datapath updates
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      last_d     = last_q;
      obs_en_d   = obs_en_q;
      grp_d      = grp_q;
      chk_edge_d = chk_edge_q;
      block_d    = block_q;
`ifdef PRM_EDGE_SCHED_CNT_EN
      cnt_d      = cnt_q;
`endif
      if (abort_i && (state_q != S_IDLE)) begin
         // Abort wins over the handshake: nothing is accepted or counted.
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_i && !abort_i) begin
                  idx_d      = {1'b0, first_edge_i};
                  last_d     = last_edge_i;
                  obs_en_d   = obs_en_i;
                  block_d    = 1'b0;
                  chk_edge_d = first_edge_i;
`ifdef PRM_EDGE_SCHED_CNT_EN
                  cnt_d      = '0;
`endif
                  if (first_edge_i > last_edge_i) begin
                     state_d = S_DONE;
                  end else if (first_in[GRP_W]) begin
                     grp_d   = first_in[GRP_W-1:0];
                     state_d = S_ISSUE;
                  end else begin
                     state_d = S_EMIT;
                  end
               end
            end
            S_ISSUE: state_d = S_SAMPLE;
            S_SAMPLE: begin
               if (hit) begin
                  block_d = 1'b1;
                  state_d = S_EMIT;
               end else if (next_lat[GRP_W]) begin
                  grp_d   = next_lat[GRP_W-1:0];
                  state_d = S_ISSUE;
               end else begin
                  block_d = 1'b0;
                  state_d = S_EMIT;
               end
            end
            S_EMIT: begin
               if (res_ready_i) begin
`ifdef PRM_EDGE_SCHED_CNT_EN
                  cnt_d = cnt_q + {{EDGE_W{1'b0}}, block_q};
`endif
                  if (idx_q == {1'b0, last_q}) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d      = idx_q + {{EDGE_W{1'b0}}, 1'b1};
                     chk_edge_d = idx_d[EDGE_W-1:0];
                     block_d    = 1'b0;
                     if (first_lat[GRP_W]) begin
                        grp_d   = first_lat[GRP_W-1:0];
                        state_d = S_ISSUE;
                     end
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs
   always_comb begin
      busy_o      = (state_q != S_IDLE);
      res_valid_o = (state_q == S_EMIT);
      done_o      = (state_q == S_DONE);
   end

   assign chk_edge_o  = chk_edge_q;
   assign chk_grp_o   = grp_q;
   assign res_edge_o  = idx_q[EDGE_W-1:0];
   assign res_block_o = block_q;
`ifdef PRM_EDGE_SCHED_CNT_EN
   assign blk_cnt_o   = cnt_q;
`endif

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// -----------------------------------------------------------------------------
// tb_prm_edge_chk_sched
//   Directed bench for prm_edge_chk_sched. A small bank model answers on
//   chk_mask from chk_edge/chk_grp. A negedge monitor logs accepted results,
//   done pulses, the groups driven while busy, and hold-stability of the
//   result outputs.
// -----------------------------------------------------------------------------
module tb_prm_edge_chk_sched;

   localparam int EDGE_W  = 15;
   localparam int NUM_OBS = 16;
   localparam int NUM_GRP = 4;
   localparam int GRP_W   = 2;

   logic                       clk = 1'b0;
   logic                       rst, start, abort, res_ready;
   logic [EDGE_W-1:0]          first_edge, last_edge;
   logic [NUM_OBS*NUM_GRP-1:0] obs_en;
   logic [EDGE_W-1:0]          chk_edge;
   logic [GRP_W-1:0]           chk_grp;
   logic [NUM_OBS-1:0]         chk_mask;
   logic                       res_valid, res_block, busy, done;
   logic [EDGE_W-1:0]          res_edge;
`ifdef PRM_EDGE_SCHED_CNT_EN
   logic [EDGE_W:0]            blk_cnt;
`endif

   always #5 clk = ~clk;

   prm_edge_chk_sched #(.EDGE_W(EDGE_W), .NUM_OBS(NUM_OBS), .NUM_GRP(NUM_GRP)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .abort_i      (abort),
      .first_edge_i (first_edge),
      .last_edge_i  (last_edge),
      .obs_en_i     (obs_en),
      .chk_edge_o   (chk_edge),
      .chk_grp_o    (chk_grp),
      .chk_mask_i   (chk_mask),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .res_edge_o   (res_edge),
      .res_block_o  (res_block),
      .busy_o       (busy),
`ifdef PRM_EDGE_SCHED_CNT_EN
      .blk_cnt_o    (blk_cnt),
`endif
      .done_o       (done)
   );

   // Bank model: every checker fires on (hit_edge, hit_grp); bg_mask elsewhere.
   logic [EDGE_W-1:0]  hit_edge;
   logic [GRP_W-1:0]   hit_grp;
   logic [NUM_OBS-1:0] bg_mask;
   always_comb chk_mask = (chk_edge == hit_edge && chk_grp == hit_grp) ? '1 : bg_mask;

   // Monitor
   int   cyc = 0;
   int   q_edge[$];
   int   q_blk[$];
   int   q_cyc[$];
   int   done_cnt = 0, done_cyc = 0, valid_cnt = 0, stab_err = 0;
   logic [NUM_GRP-1:0] grp_seen = '0;
   logic               prev_hold = 1'b0, prev_blk = 1'b0, prev_ctl = 1'b0;
   logic [EDGE_W-1:0]  prev_edge = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid && res_ready) begin
            q_edge.push_back(int'(res_edge));
            q_blk.push_back(int'(res_block));
            q_cyc.push_back(cyc);
         end
         if (res_valid) valid_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy) grp_seen[chk_grp] = 1'b1;
      end
      if (prev_hold && !prev_ctl) begin
         if (!res_valid || res_edge != prev_edge || res_block != prev_blk) stab_err++;
      end
      prev_hold = res_valid && !res_ready;
      prev_edge = res_edge;
      prev_blk  = res_block;
      prev_ctl  = abort || rst;
   end

   int n_checks = 0, n_errors = 0;
   int start_cyc = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      q_edge.delete();
      q_blk.delete();
      q_cyc.delete();
   endtask

   task automatic do_start(input logic [EDGE_W-1:0] f, input logic [EDGE_W-1:0] l,
                           input logic [NUM_OBS*NUM_GRP-1:0] en);
      first_edge = f;
      last_edge  = l;
      obs_en     = en;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      start_cyc  = cyc;
   endtask

   // Waits for one done pulse, then confirms it lasted exactly one cycle.
   task automatic wait_done(input string tag, input int budget);
      int base;
      int n;
      base = done_cnt;
      n    = 0;
      while (done_cnt == base && n < budget) begin
         tick();
         n++;
      end
      tick();
      tick();
      check({tag, " done pulses"}, 64'(done_cnt - base), 1);
      check({tag, " idle after"}, 64'(busy), 0);
   endtask

   task automatic wait_edge(input string tag, input logic [EDGE_W-1:0] e, input int budget);
      int n;
      n = 0;
      while (chk_edge != e && n < budget) begin
         tick();
         n++;
      end
      check({tag, " reached edge"}, 64'(chk_edge), 64'(e));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " chk_edge"},  64'(chk_edge), 0);
      check({tag, " chk_grp"},   64'(chk_grp), 0);
      check({tag, " res_valid"}, 64'(res_valid), 0);
      check({tag, " res_edge"},  64'(res_edge), 0);
      check({tag, " res_block"}, 64'(res_block), 0);
      check({tag, " busy"},      64'(busy), 0);
      check({tag, " done"},      64'(done), 0);
   endtask

   initial begin
      int base_done;
      int base_valid;
      rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
      first_edge = '0; last_edge = '0; obs_en = '0;
      hit_edge = 15'h1234; hit_grp = '0; bg_mask = '0;
      repeat (3) tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();

      // 1: no groups enabled -> one free result per cycle
      clear_log();
      do_start(15'd5, 15'd7, '0);
      wait_done("t1", 50);
      check("t1 count", 64'(q_edge.size()), 3);
      for (int i = 0; i < 3 && i < q_edge.size(); i++) begin
         check($sformatf("t1 edge%0d", i), 64'(q_edge[i]), 64'(5 + i));
         check($sformatf("t1 blk%0d", i), 64'(q_blk[i]), 0);
         check($sformatf("t1 cyc%0d", i), 64'(q_cyc[i] - start_cyc), 64'(i));
      end
      if (q_cyc.size() == 3) check("t1 done lat", 64'(done_cyc - q_cyc[2]), 1);

      // 2: only group 2 bit 3 enabled; other bits noisy; edge 9 hits
      clear_log();
      bg_mask = 16'hFFF7; hit_grp = 2'd2; hit_edge = 15'd9;
      grp_seen = '0;
      do_start(15'd8, 15'd10, 64'h1 << (2*NUM_OBS + 3));
      wait_done("t2", 50);
      check("t2 count", 64'(q_edge.size()), 3);
      if (q_edge.size() == 3) begin
         check("t2 edge0", 64'(q_edge[0]), 8);  check("t2 blk0", 64'(q_blk[0]), 0);
         check("t2 edge1", 64'(q_edge[1]), 9);  check("t2 blk1", 64'(q_blk[1]), 1);
         check("t2 edge2", 64'(q_edge[2]), 10); check("t2 blk2", 64'(q_blk[2]), 0);
         check("t2 first lat", 64'(q_cyc[0] - start_cyc), 2);
         check("t2 gap01", 64'(q_cyc[1] - q_cyc[0]), 3);
         check("t2 gap12", 64'(q_cyc[2] - q_cyc[1]), 3);
      end
      check("t2 groups driven", 64'(grp_seen), 64'b0100);
`ifdef PRM_EDGE_SCHED_CNT_EN
      check("t2 blk_cnt", 64'(blk_cnt), 1);
`endif

      // 3: all groups enabled; group 0 hits edge 0 (early out); edge 1 scans all 4
      clear_log();
      bg_mask = '0; hit_grp = 2'd0; hit_edge = 15'd0;
      do_start(15'd0, 15'd1, '1);
      wait_done("t3", 50);
      check("t3 count", 64'(q_edge.size()), 2);
      if (q_edge.size() == 2) begin
         check("t3 edge0", 64'(q_edge[0]), 0); check("t3 blk0", 64'(q_blk[0]), 1);
         check("t3 edge0 lat", 64'(q_cyc[0] - start_cyc), 2);
         check("t3 edge1", 64'(q_edge[1]), 1); check("t3 blk1", 64'(q_blk[1]), 0);
         check("t3 edge1 cycles", 64'(q_cyc[1] - q_cyc[0]), 9);
      end

      // 4: top of range with back-pressure; all results blocked via group 1
      clear_log();
      bg_mask = 16'h0001; hit_grp = 2'd3; hit_edge = 15'd0;
      res_ready = 1'b0;
      stab_err = 0;
      base_done = done_cnt;
      do_start(15'h7FFE, 15'h7FFF, 64'h1 << NUM_OBS);
      for (int r = 0; r < 2; r++) begin
         int n;
         n = 0;
         while (!res_valid && n < 20) begin
            tick();
            n++;
         end
         repeat (5) tick();
         res_ready = 1'b1;
         tick();
         res_ready = 1'b0;
      end
      repeat (10) tick();
      check("t4 count", 64'(q_edge.size()), 2);
      if (q_edge.size() == 2) begin
         check("t4 edge0", 64'(q_edge[0]), 15'h7FFE); check("t4 blk0", 64'(q_blk[0]), 1);
         check("t4 edge1", 64'(q_edge[1]), 15'h7FFF); check("t4 blk1", 64'(q_blk[1]), 1);
      end
      check("t4 hold stable", 64'(stab_err), 0);
      check("t4 done pulses", 64'(done_cnt - base_done), 1);
      check("t4 valid low", 64'(res_valid), 0);
      res_ready = 1'b1;

      // 5a: abort during SAMPLE of edge 3
      clear_log();
      bg_mask = '0; hit_edge = 15'd100; hit_grp = 2'd0;
      do_start(15'd0, 15'd10, 64'h1);
      wait_edge("t5a", 15'd3, 50);
      tick();                                // now in SAMPLE of edge 3
      base_done = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5a busy", 64'(busy), 0);
      check("t5a valid", 64'(res_valid), 0);
      repeat (4) tick();
      check("t5a no done", 64'(done_cnt - base_done), 0);
      check("t5a count", 64'(q_edge.size()), 3);
      clear_log();
      do_start(15'd0, 15'd0, 64'h1);
      wait_done("t5a restart", 20);
      check("t5a restart count", 64'(q_edge.size()), 1);
      if (q_edge.size() == 1) check("t5a restart edge", 64'(q_edge[0]), 0);

      // 5b: reset during SAMPLE of edge 3
      clear_log();
      do_start(15'd0, 15'd10, 64'h1);
      wait_edge("t5b", 15'd3, 50);
      tick();
      base_done = done_cnt;
      rst = 1'b1;
      tick();
      check_reset_vals("t5b");
      rst = 1'b0;
      repeat (4) tick();
      check("t5b no done", 64'(done_cnt - base_done), 0);
      check("t5b count", 64'(q_edge.size()), 3);
      clear_log();
      do_start(15'd0, 15'd0, 64'h1);
      wait_done("t5b restart", 20);
      check("t5b restart count", 64'(q_edge.size()), 1);

      // 6a: empty range -> done without results
      base_valid = valid_cnt;
      do_start(15'd9, 15'd4, 64'h1);
      wait_done("t6a", 10);
      check("t6a done lat", 64'(done_cyc - start_cyc), 0);
      check("t6a no valid", 64'(valid_cnt - base_valid), 0);

      // 6b: start and input changes while busy are ignored
      clear_log();
      do_start(15'd0, 15'd2, 64'h1);
      tick();
      first_edge = 15'd20; last_edge = 15'd20; obs_en = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t6b", 50);
      check("t6b count", 64'(q_edge.size()), 3);
      if (q_edge.size() == 3) begin
         check("t6b edge2", 64'(q_edge[2]), 2);
         check("t6b gap", 64'(q_cyc[2] - q_cyc[1]), 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
